// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a valid/ready skid buffer.
// Optional macro IMM_GEN_CSR_EN enables CSR immediate decode (fmt ZIMM).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FMT_I     = 3'd0,
        FMT_S     = 3'd1,
        FMT_B     = 3'd2,
        FMT_U     = 3'd3,
        FMT_J     = 3'd4,
        FMT_SHAMT = 3'd5,
        FMT_ZIMM  = 3'd6,
        FMT_NONE  = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt5, shamt6, zimm;
    logic [63:0] dec_imm;
    fmt_e        dec_fmt;
    logic        dec_ill;
    entry_t      dec;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // All formats are built at 64 bits and truncated, avoiding zero-width replications at XLEN=32.
    assign imm_i  = {{52{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
    assign imm_u  = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
    assign imm_j  = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
    assign shamt5 = {59'b0, in_instr[24:20]};
    assign shamt6 = {58'b0, in_instr[25:20]};
    assign zimm   = {59'b0, in_instr[19:15]};

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b1;
        case (opcode)
            7'b0000011, 7'b1100111: begin
                dec_imm = imm_i; dec_fmt = FMT_I; dec_ill = 1'b0;
            end
            7'b0010011: begin
                dec_ill = 1'b0;
                if (is_shift) begin
                    dec_imm = RV64 ? shamt6 : shamt5;
                    dec_fmt = FMT_SHAMT;
                end else begin
                    dec_imm = imm_i; dec_fmt = FMT_I;
                end
            end
            7'b0011011: begin
                if (RV64) begin
                    dec_ill = 1'b0;
                    if (is_shift) begin
                        dec_imm = shamt5; dec_fmt = FMT_SHAMT;
                    end else begin
                        dec_imm = imm_i; dec_fmt = FMT_I;
                    end
                end
            end
            7'b0100011: begin
                dec_imm = imm_s; dec_fmt = FMT_S; dec_ill = 1'b0;
            end
            7'b1100011: begin
                dec_imm = imm_b; dec_fmt = FMT_B; dec_ill = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm = imm_u; dec_fmt = FMT_U; dec_ill = 1'b0;
            end
            7'b1101111: begin
                dec_imm = imm_j; dec_fmt = FMT_J; dec_ill = 1'b0;
            end
            7'b0110011: dec_ill = 1'b0;
            7'b0111011: dec_ill = !RV64;
`ifdef IMM_GEN_CSR_EN
            7'b1110011: begin
                dec_ill = 1'b0;
                if (funct3[2]) begin
                    dec_imm = zimm; dec_fmt = FMT_ZIMM;
                end else begin
                    dec_imm = imm_i; dec_fmt = FMT_I;
                end
            end
`endif
            default: ;
        endcase
    end

    assign dec = '{imm: dec_imm[XLEN-1:0], fmt: dec_fmt, illegal: dec_ill};

    // Circular skid buffer; 1-bit pointers suffice for DEPTH of 1 or 2.
    entry_t     mem [DEPTH];
    logic       rd_ptr, wr_ptr;
    logic [1:0] count;
    logic       push, pop;
    entry_t     head;

    function automatic logic ptr_next(input logic p);
        return (DEPTH == 1) ? 1'b0 : ~p;
    endfunction

    always_comb begin
        if (DEPTH == 1) in_ready = (count == 2'd0) || out_ready;
        else            in_ready = (count < 2'(DEPTH));
    end

    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !reset && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Storage is not reset, so outputs are forced to idle values while empty.
    assign head        = mem[rd_ptr];
    assign out_imm     = out_valid ? head.imm     : '0;
    assign out_fmt     = out_valid ? head.fmt     : FMT_NONE;
    assign out_illegal = out_valid ? head.illegal : 1'b0;

endmodule
